// File: rtl/data_byte_writer.sv
// data_byte_writer: serialises a byte/half/word store into consecutive writes
// on a byte-wide data memory port, one byte per cycle, little-endian.
// Optional build macro DATA_STORE_MISALIGN_CHECK_EN: misaligned half/word
// requests are rejected (no writes) and flagged with MisalignErr.
module data_byte_writer (
    input  logic        clk,
    input  logic        Reset,
    input  logic        StoreReq,
    input  logic [31:0] StoreAddress,
    input  logic [31:0] StoreData,
    input  logic [1:0]  StoreSize,
    output logic [31:0] ByteAddress,
    output logic [7:0]  ByteData,
    output logic        ByteWrite,
    output logic        Busy,
    output logic        DoneWritingData,
    output logic        MisalignErr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [1:0]  cnt_r;
    logic [31:0] addr_r;
    logic [31:0] data_r;
    logic [1:0]  size_r;
    logic [7:0]  byte_s;
`ifdef DATA_STORE_MISALIGN_CHECK_EN
    logic        err_r;
`endif

    // Index of the last byte for a given size; reserved size 3 behaves as word.
    function automatic logic [1:0] last_index(input logic [1:0] size);
        logic [1:0] idx;
        case (size)
            2'd0:    idx = 2'd0;
            2'd1:    idx = 2'd1;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

`ifdef DATA_STORE_MISALIGN_CHECK_EN
    // A half needs an even address, a word (or reserved size) a multiple of four.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic mis;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = lsb[0];
            default: mis = (lsb != 2'd0);
        endcase
        return mis;
    endfunction
`endif

    // State register plus request capture and byte counter.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_r <= IDLE;
            cnt_r   <= 2'd0;
            addr_r  <= 32'd0;
            data_r  <= 32'd0;
            size_r  <= 2'd0;
`ifdef DATA_STORE_MISALIGN_CHECK_EN
            err_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    cnt_r <= 2'd0;
                    if (StoreReq) begin
                        addr_r <= StoreAddress;
                        data_r <= StoreData;
                        size_r <= StoreSize;
`ifdef DATA_STORE_MISALIGN_CHECK_EN
                        err_r  <= is_misaligned(StoreSize, StoreAddress[1:0]);
`endif
                    end
                end
                WRITE:   cnt_r <= cnt_r + 2'd1;
                DONE:    cnt_r <= 2'd0;
                default: cnt_r <= 2'd0;
            endcase
        end
    end

    // Next-state logic; inputs are only looked at while idle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (StoreReq) begin
`ifdef DATA_STORE_MISALIGN_CHECK_EN
                    if (is_misaligned(StoreSize, StoreAddress[1:0])) begin
                        state_s = DONE;
                    end else begin
                        state_s = WRITE;
                    end
`else
                    state_s = WRITE;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE: begin
                if (cnt_r == last_index(size_r)) begin
                    state_s = DONE;
                end else begin
                    state_s = WRITE;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Select the captured byte addressed by the counter.
    always_comb begin
        case (cnt_r)
            2'd0:    byte_s = data_r[7:0];
            2'd1:    byte_s = data_r[15:8];
            2'd2:    byte_s = data_r[23:16];
            2'd3:    byte_s = data_r[31:24];
            default: byte_s = 8'd0;
        endcase
    end

    // Output decode from registered state; memory port is quiet outside WRITE.
    always_comb begin
        ByteAddress     = 32'd0;
        ByteData        = 8'd0;
        ByteWrite       = 1'b0;
        Busy            = 1'b0;
        DoneWritingData = 1'b0;
`ifdef DATA_STORE_MISALIGN_CHECK_EN
        MisalignErr     = 1'b0;
`endif
        case (state_r)
            WRITE: begin
                ByteAddress = addr_r + {30'd0, cnt_r};
                ByteData    = byte_s;
                ByteWrite   = 1'b1;
                Busy        = 1'b1;
            end
            DONE: begin
                Busy            = 1'b1;
                DoneWritingData = 1'b1;
`ifdef DATA_STORE_MISALIGN_CHECK_EN
                MisalignErr     = err_r;
`endif
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

`ifndef DATA_STORE_MISALIGN_CHECK_EN
    assign MisalignErr = 1'b0;
`endif

endmodule

// File: tb/tb_data_byte_writer.sv
// Self-checking bench for data_byte_writer: directed vector table, hand-written
// hold/reset sequences, and randomized stores against a byte-list model.
module tb_data_byte_writer;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        StoreReq = 1'b0;
    logic [31:0] StoreAddress = 32'd0;
    logic [31:0] StoreData = 32'd0;
    logic [1:0]  StoreSize = 2'd0;
    logic [31:0] ByteAddress;
    logic [7:0]  ByteData;
    logic        ByteWrite;
    logic        Busy;
    logic        DoneWritingData;
    logic        MisalignErr;

    int tests = 0;
    int fails = 0;

    data_byte_writer dut (
        .clk(clk),
        .Reset(Reset),
        .StoreReq(StoreReq),
        .StoreAddress(StoreAddress),
        .StoreData(StoreData),
        .StoreSize(StoreSize),
        .ByteAddress(ByteAddress),
        .ByteData(ByteData),
        .ByteWrite(ByteWrite),
        .Busy(Busy),
        .DoneWritingData(DoneWritingData),
        .MisalignErr(MisalignErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      addr;
        logic [31:0]      data;
        logic [1:0]       size;
        int               n;
        logic [3:0][31:0] ea;
        logic [3:0][7:0]  eb;
        logic             err;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    // Behavioural model: list of (address, byte) writes a request must produce.
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                         output int n, output logic [3:0][31:0] ea,
                         output logic [3:0][7:0] eb, output logic err);
        int nbytes;
        logic mis;
        nbytes = (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
        mis = 1'b0;
`ifdef DATA_STORE_MISALIGN_CHECK_EN
        mis = (a % nbytes) != 0;
`endif
        ea = '0;
        eb = '0;
        for (int i = 0; i < 4; i++) begin
            ea[i] = a + 32'(i);
            eb[i] = 8'((d >> (8 * i)) & 32'hFF);
        end
        n = mis ? 0 : nbytes;
        err = mis;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".wr"}, {31'd0, ByteWrite}, 32'd0);
        chk({tag, ".busy"}, {31'd0, Busy}, 32'd0);
        chk({tag, ".done"}, {31'd0, DoneWritingData}, 32'd0);
        chk({tag, ".err"}, {31'd0, MisalignErr}, 32'd0);
        chk({tag, ".addr"}, ByteAddress, 32'd0);
        chk({tag, ".data"}, {24'd0, ByteData}, 32'd0);
    endtask

    // Checks the idle cycle, then presents a request for the coming edge.
    task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        @(negedge clk);
        check_idle("pre_idle");
        StoreReq = 1'b1;
        StoreAddress = a;
        StoreData = d;
        StoreSize = s;
    endtask

    // Checks every cycle after acceptance through the DONE pulse.
    task automatic check_store(input int n, input logic [3:0][31:0] ea,
                               input logic [3:0][7:0] eb, input logic err, input logic hold);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("w.wr", {31'd0, ByteWrite}, 32'd1);
            chk("w.addr", ByteAddress, ea[k]);
            chk("w.data", {24'd0, ByteData}, {24'd0, eb[k]});
            chk("w.busy", {31'd0, Busy}, 32'd1);
            chk("w.done", {31'd0, DoneWritingData}, 32'd0);
            chk("w.err", {31'd0, MisalignErr}, 32'd0);
            if (hold) begin
                StoreReq = 1'b1;
                StoreData = 32'h11111111;
            end else begin
                StoreReq = 1'($urandom);
                StoreAddress = $urandom;
                StoreData = $urandom;
                StoreSize = 2'($urandom);
            end
        end
        @(negedge clk);
        chk("d.wr", {31'd0, ByteWrite}, 32'd0);
        chk("d.addr", ByteAddress, 32'd0);
        chk("d.data", {24'd0, ByteData}, 32'd0);
        chk("d.busy", {31'd0, Busy}, 32'd1);
        chk("d.done", {31'd0, DoneWritingData}, 32'd1);
        chk("d.err", {31'd0, MisalignErr}, {31'd0, err});
        if (hold) begin
            StoreReq = 1'b1;
            StoreData = 32'h11111111;
        end else begin
            StoreReq = 1'b0;
        end
    endtask

    initial begin
        int n;
        logic [3:0][31:0] ea;
        logic [3:0][7:0] eb;
        logic err;
        logic [31:0] ra;
        logic [1:0] rs;

        vt[0] = '{32'h100, 32'hDEADBEEF, 2'd2, 4,
                  {32'h103, 32'h102, 32'h101, 32'h100}, {8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b0};
        vt[1] = '{32'h23, 32'h000000A5, 2'd0, 1,
                  {32'h0, 32'h0, 32'h0, 32'h23}, {8'h0, 8'h0, 8'h0, 8'hA5}, 1'b0};
        vt[2] = '{32'h40, 32'h00001234, 2'd1, 2,
                  {32'h0, 32'h0, 32'h41, 32'h40}, {8'h0, 8'h0, 8'h12, 8'h34}, 1'b0};
        vt[3] = '{32'h200, 32'h01020304, 2'd3, 4,
                  {32'h203, 32'h202, 32'h201, 32'h200}, {8'h01, 8'h02, 8'h03, 8'h04}, 1'b0};
`ifdef DATA_STORE_MISALIGN_CHECK_EN
        vt[4] = '{32'h102, 32'h55667788, 2'd2, 0, '0, '0, 1'b1};
        vt[5] = '{32'hFFFFFFFE, 32'hA1B2C3D4, 2'd2, 0, '0, '0, 1'b1};
        vt[6] = '{32'h41, 32'h0000BEEF, 2'd1, 0, '0, '0, 1'b1};
`else
        vt[4] = '{32'h102, 32'h55667788, 2'd2, 4,
                  {32'h105, 32'h104, 32'h103, 32'h102}, {8'h55, 8'h66, 8'h77, 8'h88}, 1'b0};
        vt[5] = '{32'hFFFFFFFE, 32'hA1B2C3D4, 2'd2, 4,
                  {32'h1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE}, {8'hA1, 8'hB2, 8'hC3, 8'hD4}, 1'b0};
        vt[6] = '{32'h41, 32'h0000BEEF, 2'd1, 2,
                  {32'h0, 32'h0, 32'h42, 32'h41}, {8'h0, 8'h0, 8'hBE, 8'hEF}, 1'b0};
`endif

        // Reset state, with a request pending to show reset wins.
        StoreReq = 1'b1;
        StoreAddress = 32'h100;
        StoreSize = 2'd2;
        repeat (3) @(negedge clk);
        check_idle("reset");
        Reset = 1'b0;
        StoreReq = 1'b0;

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            drive_req(vt[i].addr, vt[i].data, vt[i].size);
            check_store(vt[i].n, vt[i].ea, vt[i].eb, vt[i].err, 1'b0);
        end

        // Request held high across a store with changed data: one idle cycle, then a new store.
        drive_req(32'h300, 32'hCAFEF00D, 2'd2);
        model(32'h300, 32'hCAFEF00D, 2'd2, n, ea, eb, err);
        check_store(n, ea, eb, err, 1'b1);
        @(negedge clk);
        check_idle("hold_gap");
        model(32'h300, 32'h11111111, 2'd2, n, ea, eb, err);
        check_store(n, ea, eb, err, 1'b0);

        // Reset while writing byte 2 of a word store.
        drive_req(32'h100, 32'hDEADBEEF, 2'd2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            StoreReq = 1'b0;
            chk("rst_mid.wr", {31'd0, ByteWrite}, 32'd1);
            chk("rst_mid.addr", ByteAddress, 32'h100 + 32'(k));
        end
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        check_idle("rst_abort");
        @(negedge clk);
        check_idle("rst_after");

        // Randomized stores against the model.
        for (int r = 0; r < 60; r++) begin
            ra = $urandom;
            if (r % 8 == 0) ra = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            rs = 2'($urandom);
            model(ra, $urandom, rs, n, ea, eb, err);
            drive_req(ra, 32'(eb), rs);
            check_store(n, ea, eb, err, 1'b0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
